// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between an instruction cache (ic) and a
// data cache (dc).
//
// Each cache port has a one-entry pending slot. A request is either a
// WIDTH-bit write or a BLOCKSZ-bit line read. The line read is assembled
// from BEATS bus beats.
//
// Ports:
//   clk, rst                  single clock, async active-high reset
//   {ic,dc}_mem_req           one-cycle request pulse
//   {ic,dc}_mem_address       request address
//   {ic,dc}_mem_wr_en         1 = single-beat write, 0 = line read
//   {ic,dc}_mem_data_out      write data
//   {ic,dc}_mem_data_in       last completed read line for that port
//   {ic,dc}_mem_data_valid    one-cycle completion pulse
//   bus_reqcyc/reqack         request handshake (addr, we, wdata qualified by reqcyc)
//   bus_respcyc/resp/respack  read beat handshake
module mem_arbiter #(
  parameter int ADDRESSSIZE = 64,
  parameter int WIDTH       = 64,
  parameter int BLOCKSZ     = 512,
  parameter int BEATS       = BLOCKSZ / WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_mem_req,
  input  logic [ADDRESSSIZE-1:0] ic_mem_address,
  input  logic                   ic_mem_wr_en,
  input  logic [WIDTH-1:0]       ic_mem_data_out,
  output logic [BLOCKSZ-1:0]     ic_mem_data_in,
  output logic                   ic_mem_data_valid,
  input  logic                   dc_mem_req,
  input  logic [ADDRESSSIZE-1:0] dc_mem_address,
  input  logic                   dc_mem_wr_en,
  input  logic [WIDTH-1:0]       dc_mem_data_out,
  output logic [BLOCKSZ-1:0]     dc_mem_data_in,
  output logic                   dc_mem_data_valid,
  output logic                   bus_reqcyc,
  input  logic                   bus_reqack,
  output logic [ADDRESSSIZE-1:0] bus_addr,
  output logic                   bus_we,
  output logic [WIDTH-1:0]       bus_wdata,
  input  logic                   bus_respcyc,
  input  logic [WIDTH-1:0]       bus_resp,
  output logic                   bus_respack
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, READ, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   ic_pend_q, ic_pend_d, dc_pend_q, dc_pend_d;
  logic [ADDRESSSIZE-1:0] ic_addr_q, ic_addr_d, dc_addr_q, dc_addr_d;
  logic                   ic_we_q, ic_we_d, dc_we_q, dc_we_d;
  logic [WIDTH-1:0]       ic_wdata_q, ic_wdata_d, dc_wdata_q, dc_wdata_d;
  logic                   gnt_ic_q, gnt_ic_d;   // 1 = ic owns the bus, 0 = dc
  logic                   last_ic_q, last_ic_d; // last serviced port was ic
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BLOCKSZ-1:0]     line_q, line_d;       // assembly buffer
  logic [BLOCKSZ-1:0]     ic_line_q, ic_line_d, dc_line_q, dc_line_d;

  logic [ADDRESSSIZE-1:0] g_addr;
  logic                   g_we;
  logic [WIDTH-1:0]       g_wdata;

  assign g_addr  = gnt_ic_q ? ic_addr_q  : dc_addr_q;
  assign g_we    = gnt_ic_q ? ic_we_q    : dc_we_q;
  assign g_wdata = gnt_ic_q ? ic_wdata_q : dc_wdata_q;

  assign ic_mem_data_in = ic_line_q;
  assign dc_mem_data_in = dc_line_q;

  always_comb begin
    state_d    = state_q;
    ic_pend_d  = ic_pend_q;
    dc_pend_d  = dc_pend_q;
    ic_addr_d  = ic_addr_q;
    dc_addr_d  = dc_addr_q;
    ic_we_d    = ic_we_q;
    dc_we_d    = dc_we_q;
    ic_wdata_d = ic_wdata_q;
    dc_wdata_d = dc_wdata_q;
    gnt_ic_d   = gnt_ic_q;
    last_ic_d  = last_ic_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    ic_line_d  = ic_line_q;
    dc_line_d  = dc_line_q;

    bus_reqcyc        = 1'b0;
    bus_addr          = '0;
    bus_we            = 1'b0;
    bus_wdata         = '0;
    bus_respack       = 1'b0;
    ic_mem_data_valid = 1'b0;
    dc_mem_data_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (ic_pend_q || dc_pend_q) begin
          // On a tie, serve the port that was not served last.
          gnt_ic_d = ic_pend_q && (!dc_pend_q || !last_ic_q);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        bus_reqcyc = 1'b1;
        bus_we     = g_we;
        bus_wdata  = g_wdata;
        // Line reads are aligned to the 64-byte line; writes go out as given.
        bus_addr   = g_we ? g_addr : {g_addr[ADDRESSSIZE-1:6], 6'b0};
        if (bus_reqack) state_d = g_we ? DONE : READ;
      end
      READ: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) begin
          line_d[cnt_q*WIDTH +: WIDTH] = bus_resp;
          if (cnt_q == CW'(BEATS-1)) begin
            cnt_d   = '0;
            state_d = DONE;
            // Publish the whole line together with the final beat.
            // This way data_in is already valid in the DONE cycle.
            if (gnt_ic_q) ic_line_d = line_d;
            else          dc_line_d = line_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        ic_mem_data_valid = gnt_ic_q;
        dc_mem_data_valid = !gnt_ic_q;
        if (gnt_ic_q) ic_pend_d = 1'b0;
        else          dc_pend_d = 1'b0;
        last_ic_d = gnt_ic_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Requests are latched against the post-completion slot state.
    // A request arriving in the DONE cycle of its own port is therefore kept.
    if (ic_mem_req && !ic_pend_d) begin
      ic_pend_d  = 1'b1;
      ic_addr_d  = ic_mem_address;
      ic_we_d    = ic_mem_wr_en;
      ic_wdata_d = ic_mem_data_out;
    end
    if (dc_mem_req && !dc_pend_d) begin
      dc_pend_d  = 1'b1;
      dc_addr_d  = dc_mem_address;
      dc_we_d    = dc_mem_wr_en;
      dc_wdata_d = dc_mem_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ic_pend_q  <= 1'b0;
      dc_pend_q  <= 1'b0;
      ic_addr_q  <= '0;
      dc_addr_q  <= '0;
      ic_we_q    <= 1'b0;
      dc_we_q    <= 1'b0;
      ic_wdata_q <= '0;
      dc_wdata_q <= '0;
      gnt_ic_q   <= 1'b0;
      last_ic_q  <= 1'b1; // the first tie goes to dc
      cnt_q      <= '0;
      line_q     <= '0;
      ic_line_q  <= '0;
      dc_line_q  <= '0;
    end else begin
      state_q    <= state_d;
      ic_pend_q  <= ic_pend_d;
      dc_pend_q  <= dc_pend_d;
      ic_addr_q  <= ic_addr_d;
      dc_addr_q  <= dc_addr_d;
      ic_we_q    <= ic_we_d;
      dc_we_q    <= dc_we_d;
      ic_wdata_q <= ic_wdata_d;
      dc_wdata_q <= dc_wdata_d;
      gnt_ic_q   <= gnt_ic_d;
      last_ic_q  <= last_ic_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      ic_line_q  <= ic_line_d;
      dc_line_q  <= dc_line_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         ic_mem_req, dc_mem_req, ic_mem_wr_en, dc_mem_wr_en;
  logic [63:0]  ic_mem_address, dc_mem_address, ic_mem_data_out, dc_mem_data_out;
  logic [511:0] ic_mem_data_in, dc_mem_data_in;
  logic         ic_mem_data_valid, dc_mem_data_valid;
  logic         bus_reqcyc, bus_reqack, bus_we, bus_respcyc, bus_respack;
  logic [63:0]  bus_addr, bus_wdata, bus_resp;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_mem_req(ic_mem_req), .ic_mem_address(ic_mem_address), .ic_mem_wr_en(ic_mem_wr_en),
    .ic_mem_data_out(ic_mem_data_out), .ic_mem_data_in(ic_mem_data_in),
    .ic_mem_data_valid(ic_mem_data_valid),
    .dc_mem_req(dc_mem_req), .dc_mem_address(dc_mem_address), .dc_mem_wr_en(dc_mem_wr_en),
    .dc_mem_data_out(dc_mem_data_out), .dc_mem_data_in(dc_mem_data_in),
    .dc_mem_data_valid(dc_mem_data_valid),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  typedef struct {bit ic; logic [511:0] line; int cyc;} sb_t;
  typedef struct {logic [63:0] addr; bit we; logic [63:0] wdata; int hold;} bt_t;

  sb_t          sb_q[$];
  bt_t          bus_q[$];
  logic [63:0]  rsp_q[$];
  int           checks = 0, errors = 0, cyc = 0;
  int           ack_dly = 0, gap = 0;
  logic [511:0] exp_ic = '0, exp_dc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic push_bus(input logic [63:0] a, input bit we, input logic [63:0] wd, input int hold);
    bt_t b;
    b.addr = a; b.we = we; b.wdata = wd; b.hold = hold;
    bus_q.push_back(b);
  endtask

  task automatic push_sb(input bit ic, input logic [511:0] line, input int c);
    sb_t s;
    s.ic = ic; s.line = line; s.cyc = c;
    sb_q.push_back(s);
  endtask

  task automatic drive(input bit ic, input bit we, input logic [63:0] a, input logic [63:0] d);
    if (ic) begin
      ic_mem_req = 1; ic_mem_wr_en = we; ic_mem_address = a; ic_mem_data_out = d;
    end else begin
      dc_mem_req = 1; dc_mem_wr_en = we; dc_mem_address = a; dc_mem_data_out = d;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    ic_mem_req = 0; dc_mem_req = 0;
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((sb_q.size() != 0 || bus_q.size() != 0) && t < 400) begin
      @(negedge clk); t++;
    end
    if (t >= 400) begin
      errors++; checks++;
      $display("FAIL %s timeout: sb=%0d bus=%0d pending", nm, sb_q.size(), bus_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_ic = '0; exp_dc = '0;
    @(negedge clk);
  endtask

  // Bus slave model: acks after ack_dly cycles, returns 8 beats for reads.
  // A gap of idle cycles precedes each beat.
  initial begin
    logic        we_l;
    logic [63:0] base;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_reqcyc) begin
        repeat (ack_dly) begin @(posedge clk); #1; end
        bus_reqack = 1; we_l = bus_we;
        @(posedge clk); #1;
        bus_reqack = 0;
        if (!we_l) begin
          base = (rsp_q.size() > 0) ? rsp_q.pop_front() : 64'h0;
          for (int k = 0; k < 8; k++) begin
            repeat (gap) begin @(posedge clk); #1; end
            bus_respcyc = 1; bus_resp = base + 64'(k);
            @(posedge clk); #1;
            bus_respcyc = 0;
          end
        end
      end
    end
  end

  // Completion monitor
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst && ic_mem_data_valid && dc_mem_data_valid) begin
        checks++; errors++;
        $display("FAIL both_valid: ic=1 dc=1 required at most one");
      end else if (!rst && (ic_mem_data_valid || dc_mem_data_valid)) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: ic=%0b dc=%0b required none", ic_mem_data_valid, dc_mem_data_valid);
        end else begin
          e = sb_q.pop_front();
          chk("valid_port_ic", ic_mem_data_valid, e.ic);
          chk("data_in", e.ic ? ic_mem_data_in : dc_mem_data_in, e.line);
          if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Bus request monitor
  initial begin
    int  hold;
    bt_t b;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else if (bus_reqcyc) begin
        hold++;
        if (bus_reqack) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bus_req: addr=%h required none", bus_addr);
          end else begin
            b = bus_q.pop_front();
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_we", bus_we, b.we);
            if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
            if (b.hold >= 0) chk("reqcyc_hold", hold, b.hold);
          end
          hold = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    rst = 1;
    ic_mem_req = 0; dc_mem_req = 0; ic_mem_wr_en = 0; dc_mem_wr_en = 0;
    ic_mem_address = '0; dc_mem_address = '0; ic_mem_data_out = '0; dc_mem_data_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_reqcyc", bus_reqcyc, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_respack", bus_respack, 0);
    chk("rst_valids", {ic_mem_data_valid, dc_mem_data_valid}, 0);
    chk("rst_ic_line", ic_mem_data_in, 0);
    chk("rst_dc_line", dc_mem_data_in, 0);
    rst = 0;
    @(negedge clk);

    // dc line read, immediate ack, beats 0..7
    push_bus(64'h1040, 0, 0, 1); rsp_q.push_back(64'h0);
    exp_dc = mk_line(64'h0); push_sb(0, exp_dc, cyc + 11);
    drive(0, 0, 64'h1047, 0); release_req();
    wait_drain("dc_read");

    // simultaneous ic+dc after reset: dc first
    do_reset();
    push_bus(64'h3000, 0, 0, 1); rsp_q.push_back(64'h100);
    exp_dc = mk_line(64'h100); push_sb(0, exp_dc, cyc + 11);
    push_bus(64'h4000, 0, 0, -1); rsp_q.push_back(64'h200);
    exp_ic = mk_line(64'h200); push_sb(1, exp_ic, -1);
    drive(0, 0, 64'h3000, 0); drive(1, 0, 64'h4000, 0); release_req();
    wait_drain("both_read");

    // dc write, ack delayed 3 cycles; dc line must stay unchanged
    ack_dly = 3;
    push_bus(64'h2008, 1, 64'hDEADBEEF, 4); push_sb(0, exp_dc, -1);
    drive(0, 1, 64'h2008, 64'hDEADBEEF); release_req();
    wait_drain("dc_write");
    ack_dly = 0;
    chk("write_keeps_line", dc_mem_data_in, exp_dc);

    // beats with gaps
    gap = 2;
    push_bus(64'h5000, 0, 0, 1); rsp_q.push_back(64'h300);
    exp_ic = mk_line(64'h300); push_sb(1, exp_ic, -1);
    drive(1, 0, 64'h5010, 0); release_req();
    wait_drain("gap_read");
    gap = 0;

    // reset after the 4th beat: no pulse, outputs cleared
    push_bus(64'h6000, 0, 0, 1); rsp_q.push_back(64'h400);
    drive(0, 0, 64'h6000, 0); release_req();
    n = 0; t = 0;
    while (n < 4 && t < 100) begin
      @(negedge clk); t++;
      if (bus_respcyc && bus_respack) n++;
    end
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL beat_wait timeout: beats=%0d required 4", n);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_reqcyc", bus_reqcyc, 0);
    chk("midrst_respack", bus_respack, 0);
    chk("midrst_valids", {ic_mem_data_valid, dc_mem_data_valid}, 0);
    chk("midrst_dc_line", dc_mem_data_in, 0);
    chk("midrst_ic_line", ic_mem_data_in, 0);
    rst = 0; exp_ic = '0; exp_dc = '0;
    repeat (20) @(negedge clk);
    chk("midrst_bus_q", bus_q.size(), 0);
    push_bus(64'h7000, 0, 0, 1); rsp_q.push_back(64'h500);
    exp_dc = mk_line(64'h500); push_sb(0, exp_dc, cyc + 11);
    drive(0, 0, 64'h7000, 0); release_req();
    wait_drain("post_rst_read");

    // second ic req while pending is ignored
    push_bus(64'h8040, 0, 0, 1); rsp_q.push_back(64'h600);
    exp_ic = mk_line(64'h600); push_sb(1, exp_ic, cyc + 11);
    drive(1, 0, 64'h8040, 0); release_req();
    drive(1, 0, 64'h9000, 0); release_req();
    wait_drain("dup_req");
    repeat (20) @(negedge clk);

    // new ic req in its own DONE cycle is kept
    push_bus(64'hA000, 0, 0, 1); rsp_q.push_back(64'h700);
    push_sb(1, mk_line(64'h700), cyc + 11);
    push_bus(64'hB000, 0, 0, -1); rsp_q.push_back(64'h800);
    exp_ic = mk_line(64'h800); push_sb(1, exp_ic, -1);
    drive(1, 0, 64'hA000, 0); release_req();
    t = 0;
    while (!ic_mem_data_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL done_wait timeout: ic valid not seen");
    end
    drive(1, 0, 64'hB000, 0); release_req();
    wait_drain("done_cycle_req");

    repeat (20) @(negedge clk);
    chk("end_sb_empty", sb_q.size(), 0);
    chk("end_bus_empty", bus_q.size(), 0);
    chk("end_rsp_empty", rsp_q.size(), 0);
    chk("end_reqcyc", bus_reqcyc, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
